// File: rtl/adc_lvds_pkg.sv
// Shared types and helpers for the ADC LVDS transmit path.
package adc_lvds_pkg;

  typedef enum logic [1:0] {
    TXM_STREAM = 2'd0,
    TXM_RAMP   = 2'd1,
    TXM_TRAIN  = 2'd2,
    TXM_PRBS   = 2'd3
  } tx_mode_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_TRAIN = 2'd1,
    TX_RUN   = 2'd2
  } tx_state_e;

  localparam logic [14:0] PRBS15_SEED = 15'h7FFF;

  // Widest lane count the split helper handles; narrower words are zero-extended.
  localparam int unsigned MAX_LANES = 16;
  localparam int unsigned MAX_W     = 2 * MAX_LANES;

  typedef struct packed {
    logic [MAX_LANES-1:0] rise;
    logic [MAX_LANES-1:0] fall;
  } lane_pair_t;

  // Even word bits go out on the rising DCO edge, odd bits on the falling edge.
  function automatic lane_pair_t lane_split(input logic [MAX_W-1:0] word);
    lane_pair_t p;
    for (int i = 0; i < int'(MAX_LANES); i++) begin
      p.rise[i] = word[2*i];
      p.fall[i] = word[2*i+1];
    end
    return p;
  endfunction

endpackage

// File: rtl/adc_lvds_tx_serializer_prbs.sv
// PRBS-15 (x^15 + x^14 + 1) source producing W serial bits per advance, MSB first.
// Only instantiated when ADC_TX_PRBS_EN is defined.
module adc_prbs15_gen
  import adc_lvds_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         restart_i,
  input  logic         advance_i,
  output logic [W-1:0] word_o
);

  logic [14:0] lfsr_q, lfsr_d;
  logic [14:0] step;
  logic        fb;

  // word_o is always the next W bits; the state only moves when they are consumed.
  always_comb begin
    step   = lfsr_q;
    fb     = 1'b0;
    word_o = '0;
    for (int k = 0; k < int'(W); k++) begin
      fb                = step[14] ^ step[13];
      word_o[W-1-k]     = fb;
      step              = {step[13:0], fb};
    end
    if (restart_i) begin
      lfsr_d = PRBS15_SEED;
    end else if (advance_i) begin
      lfsr_d = step;
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PRBS15_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/adc_lvds_tx_serializer.sv
// DDR lane serializer with FCO framing: stream / ramp / training / PRBS word sources.
// Define ADC_TX_PRBS_EN to build the PRBS-15 source for mode 3; otherwise mode 3 sends the ramp.
module adc_lvds_tx_serializer
  import adc_lvds_pkg::*;
#(
  parameter int unsigned        LANES        = 8,
  parameter int unsigned        FRAME_PERIOD = 16,
  parameter int unsigned        TRAIN_LEN    = 64,
  parameter logic [2*LANES-1:0] TRAIN_WORD   = 16'hA5C3
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic [1:0]           mode_i,
  input  logic                 stall_i,
  input  logic [2*LANES-1:0]   in_word_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [LANES-1:0]     tx_rise_o,
  output logic [LANES-1:0]     tx_fall_o,
  output logic                 tx_fco_o,
  output logic                 tx_word_valid_o,
  output logic                 underrun_o,
  output logic [31:0]          word_count_o
);

  localparam int unsigned W   = 2 * LANES;
  localparam int unsigned FCW = $clog2(FRAME_PERIOD);
  localparam int unsigned TCW = $clog2(TRAIN_LEN + 1);

  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_PERIOD - 1);
  localparam logic [TCW-1:0] TRAIN_LAST = TCW'(TRAIN_LEN - 1);

  tx_state_e        state_q, state_d;
  tx_mode_e         mode_q, mode_d;
  logic [FCW-1:0]   frame_q, frame_d;
  logic [TCW-1:0]   train_cnt_q, train_cnt_d;
  logic [W-1:0]     ramp_q, ramp_d;
  logic [31:0]      word_count_q, word_count_d;
  logic             underrun_q, underrun_d;
  logic [LANES-1:0] rise_q, rise_d, fall_q, fall_d;
  logic             fco_q, fco_d;
  logic             valid_q, valid_d;

  logic             emit_ok;
  logic             word_avail;
  logic             emit;
  logic             ramp_adv;
  logic             prbs_restart;
  logic [W-1:0]     src_word;
  lane_pair_t       split;
  logic             unused_split;

`ifdef ADC_TX_PRBS_EN
  logic             prbs_adv;
  logic [W-1:0]     prbs_word;

  adc_prbs15_gen #(
    .W (W)
  ) u_prbs (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .restart_i (prbs_restart),
    .advance_i (prbs_adv),
    .word_o    (prbs_word)
  );
`endif

  assign in_ready_o = (state_q == TX_RUN) && (mode_q == TXM_STREAM) && !stall_i && enable_i;
  assign emit_ok    = enable_i && !stall_i;

  // Word source selection; TRAIN and ramp/PRBS always have a word ready.
  always_comb begin
    word_avail = 1'b0;
    src_word   = '0;
    ramp_adv   = 1'b0;
`ifdef ADC_TX_PRBS_EN
    prbs_adv   = 1'b0;
`endif
    case (state_q)
      TX_TRAIN: begin
        word_avail = 1'b1;
        src_word   = TRAIN_WORD;
      end
      TX_RUN: begin
        case (mode_q)
          TXM_STREAM: begin
            word_avail = in_valid_i && in_ready_o;
            src_word   = in_word_i;
          end
`ifdef ADC_TX_PRBS_EN
          TXM_PRBS: begin
            word_avail = 1'b1;
            src_word   = prbs_word;
            prbs_adv   = emit_ok;
          end
`endif
          default: begin
            word_avail = 1'b1;
            src_word   = ramp_q;
            ramp_adv   = emit_ok;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign emit         = emit_ok && word_avail;
  assign split        = lane_split(MAX_W'(src_word));
  assign unused_split = ^split;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    frame_d      = frame_q;
    train_cnt_d  = train_cnt_q;
    ramp_d       = ramp_q;
    word_count_d = word_count_q;
    underrun_d   = underrun_q;
    rise_d       = rise_q;
    fall_d       = fall_q;
    fco_d        = 1'b0;
    valid_d      = 1'b0;
    prbs_restart = 1'b0;

    if (!enable_i) begin
      // Abandon any partial frame; lanes idle low.
      state_d = TX_IDLE;
      rise_d  = '0;
      fall_d  = '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          state_d      = TX_TRAIN;
          mode_d       = tx_mode_e'(mode_i);
          frame_d      = '0;
          train_cnt_d  = '0;
          ramp_d       = '0;
          word_count_d = '0;
          underrun_d   = 1'b0;
          prbs_restart = 1'b1;
        end
        TX_TRAIN: begin
          if (emit && (train_cnt_q == TRAIN_LAST) && (mode_q != TXM_TRAIN)) begin
            state_d = TX_RUN;
          end
        end
        default: ;
      endcase

      if (emit) begin
        rise_d       = split.rise[LANES-1:0];
        fall_d       = split.fall[LANES-1:0];
        valid_d      = 1'b1;
        fco_d        = (frame_q == '0);
        frame_d      = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
        word_count_d = word_count_q + 32'd1;
        if ((state_q == TX_TRAIN) && (train_cnt_q != TRAIN_LAST)) begin
          train_cnt_d = train_cnt_q + 1'b1;
        end
        if (ramp_adv) begin
          ramp_d = ramp_q + 1'b1;
        end
      end

      if ((state_q == TX_RUN) && (mode_q == TXM_STREAM) && !stall_i && !in_valid_i) begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TX_IDLE;
      mode_q       <= TXM_STREAM;
      frame_q      <= '0;
      train_cnt_q  <= '0;
      ramp_q       <= '0;
      word_count_q <= '0;
      underrun_q   <= 1'b0;
      rise_q       <= '0;
      fall_q       <= '0;
      fco_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      frame_q      <= frame_d;
      train_cnt_q  <= train_cnt_d;
      ramp_q       <= ramp_d;
      word_count_q <= word_count_d;
      underrun_q   <= underrun_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      fco_q        <= fco_d;
      valid_q      <= valid_d;
    end
  end

  assign tx_rise_o       = rise_q;
  assign tx_fall_o       = fall_q;
  assign tx_fco_o        = fco_q;
  assign tx_word_valid_o = valid_q;
  assign underrun_o      = underrun_q;
  assign word_count_o    = word_count_q;

endmodule
